// File: rtl/board_port_arbiter_if.sv
// board_port_arbiter_if
//  Bundles the three requester ports, the shared read-return bus and the
//  board RAM port of board_port_arbiter.
//  slave  : arbiter side (takes requests, drives readys/rvalid/rdata and mem_*)
//  master : requester side (drives requests, observes readys/rvalid/rdata)
//  ram    : board RAM side (observes mem_*, drives mem_rdata)
//  reqN_* : N=0 gamelogic, 1 line-clear, 2 painter
interface board_port_arbiter_if;
  logic       req0_valid, req1_valid, req2_valid;
  logic       req0_we,    req1_we,    req2_we;
  logic [3:0] req0_x,     req1_x,     req2_x;
  logic [4:0] req0_y,     req1_y,     req2_y;
  logic       req0_wdata, req1_wdata, req2_wdata;
  logic       req0_ready, req1_ready, req2_ready;
  logic       req0_lock;
  logic [2:0] rvalid;
  logic       rdata;
  logic       mem_en;
  logic       mem_we;
  logic [3:0] mem_x;
  logic [4:0] mem_y;
  logic       mem_wdata;
  logic       mem_rdata;

  modport slave (
    input  req0_valid, req1_valid, req2_valid,
    input  req0_we, req1_we, req2_we,
    input  req0_x, req1_x, req2_x,
    input  req0_y, req1_y, req2_y,
    input  req0_wdata, req1_wdata, req2_wdata,
    input  req0_lock,
    output req0_ready, req1_ready, req2_ready,
    output rvalid, rdata,
    output mem_en, mem_we, mem_x, mem_y, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req1_valid, req2_valid,
    output req0_we, req1_we, req2_we,
    output req0_x, req1_x, req2_x,
    output req0_y, req1_y, req2_y,
    output req0_wdata, req1_wdata, req2_wdata,
    output req0_lock,
    input  req0_ready, req1_ready, req2_ready,
    input  rvalid, rdata
  );

  modport ram (
    input  mem_en, mem_we, mem_x, mem_y, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/board_port_arbiter.sv
// board_port_arbiter
//  Shares the single-port 10x20 playfield board RAM between gamelogic (0),
//  line-clear (1) and the VGA painter (2). One access is granted per cycle,
//  read data comes back RD_LAT cycles later tagged one-hot to its issuer, and
//  gamelogic can lock the port for atomic read-modify-write sequences.
//  Ports:
//    CLOCK_50 : system clock, all state on posedge
//    reset    : asynchronous active-high, clears all state
//    bus      : board_port_arbiter_if.slave (requests, readys, rvalid/rdata, RAM port)
//
//  state     | meaning
//  ST_OPEN   | normal arbitration: starved painter, gamelogic, then line-clear/painter round-robin
//  ST_LOCKED | gamelogic owns the port; nobody else is granted until lock is sampled low
module board_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15,
  parameter int STARVE_W   = 4
) (
  input logic                CLOCK_50,
  input logic                reset,
  board_port_arbiter_if.slave bus
);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state, state_nxt;
  logic                rr_ptr, rr_ptr_nxt;   // 0: line-clear wins a tie, 1: painter wins
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic [2:0]          gnt;
  logic                acc;
  logic [1:0]          sel_id;
  logic                sel_we;
  logic [3:0]          sel_x;
  logic [4:0]          sel_y;
  logic                sel_wdata;
  logic                in_range;

  logic [RD_LAT-1:0]   pipe_v;
  logic [RD_LAT-1:0]   pipe_ir;
  logic [1:0]          pipe_id [RD_LAT];

  // Grant selection and next-state
  always_comb begin
    gnt        = 3'b000;
    rr_ptr_nxt = rr_ptr;
    state_nxt  = state;
    if (!reset) begin
      if (state == ST_LOCKED) begin
        if (bus.req0_valid) gnt = 3'b001;
      end else if (bus.req2_valid && (starve_cnt >= STARVE_LIM)) begin
        gnt = 3'b100;
      end else if (bus.req0_valid) begin
        gnt = 3'b001;
      end else if (bus.req1_valid && bus.req2_valid) begin
        gnt        = rr_ptr ? 3'b100 : 3'b010;
        rr_ptr_nxt = !rr_ptr;
      end else if (bus.req1_valid) begin
        gnt        = 3'b010;
        rr_ptr_nxt = 1'b1;
      end else if (bus.req2_valid) begin
        gnt        = 3'b100;
        rr_ptr_nxt = 1'b0;
      end
    end
    case (state)
      ST_OPEN:   if (gnt[0] && bus.req0_lock) state_nxt = ST_LOCKED;
      ST_LOCKED: if (!bus.req0_lock)          state_nxt = ST_OPEN;
      default:   state_nxt = ST_OPEN;
    endcase
  end

  // Painter starvation counter: counts only while the painter is waiting
  always_comb begin
    starve_nxt = starve_cnt;
    if (!bus.req2_valid || gnt[2])
      starve_nxt = '0;
    else if (starve_cnt != '1)
      starve_nxt = starve_cnt + STARVE_W'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_OPEN;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Accepted request mux
  always_comb begin
    sel_id    = 2'd0;
    sel_we    = 1'b0;
    sel_x     = 4'd0;
    sel_y     = 5'd0;
    sel_wdata = 1'b0;
    if (gnt[0]) begin
      sel_id = 2'd0; sel_we = bus.req0_we; sel_x = bus.req0_x;
      sel_y  = bus.req0_y; sel_wdata = bus.req0_wdata;
    end else if (gnt[1]) begin
      sel_id = 2'd1; sel_we = bus.req1_we; sel_x = bus.req1_x;
      sel_y  = bus.req1_y; sel_wdata = bus.req1_wdata;
    end else if (gnt[2]) begin
      sel_id = 2'd2; sel_we = bus.req2_we; sel_x = bus.req2_x;
      sel_y  = bus.req2_y; sel_wdata = bus.req2_wdata;
    end
  end

  assign acc            = |gnt;
  assign in_range       = (sel_x <= 4'd9) && (sel_y <= 5'd19);
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.req2_ready = gnt[2];

  // Out-of-range accesses are accepted but never reach the RAM
  assign bus.mem_en    = acc && in_range;
  assign bus.mem_we    = bus.mem_en && sel_we;
  assign bus.mem_x     = acc ? sel_x : 4'd0;
  assign bus.mem_y     = acc ? sel_y : 5'd0;
  assign bus.mem_wdata = bus.mem_we && sel_wdata;

  // Read return pipeline, aligned with the RAM read latency
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pipe_v  <= '0;
      pipe_ir <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_id[i] <= 2'd0;
    end else begin
      pipe_v[0]  <= acc && !sel_we;
      pipe_ir[0] <= in_range;
      pipe_id[0] <= sel_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_ir[i] <= pipe_ir[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign bus.rvalid = pipe_v[RD_LAT-1] ? (3'b001 << pipe_id[RD_LAT-1]) : 3'b000;
  assign bus.rdata  = pipe_v[RD_LAT-1] && pipe_ir[RD_LAT-1] && bus.mem_rdata;

endmodule

// File: tb/tb_board_port_arbiter.sv
module tb_board_port_arbiter;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 15;
  localparam int STARVE_SAT = 15;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  board_port_arbiter_if bus ();

  board_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .STARVE_W(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  // Board RAM: one-cycle synchronous read, write-first ordering by cycle
  logic ram [10][20];
  logic rd_q = 1'b0;
  assign bus.mem_rdata = rd_q;
  initial for (int i = 0; i < 10; i++) for (int j = 0; j < 20; j++) ram[i][j] = 1'b0;
  always @(posedge CLOCK_50) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_x][bus.mem_y] <= bus.mem_wdata;
      else            rd_q <= ram[bus.mem_x][bus.mem_y];
    end
  end

  // Reference model state
  typedef struct {int due; int id; int val;} rd_t;
  rd_t q[$];
  bit  board [10][20];
  bit  locked;
  int  rr_next;   // requester that wins a line-clear/painter tie
  int  starve;
  int  cyc;
  int  n_chk, n_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int n, input bit v, input bit we, input int x, input int y, input bit wd);
    case (n)
      0: begin bus.req0_valid = v; bus.req0_we = we; bus.req0_x = 4'(x); bus.req0_y = 5'(y); bus.req0_wdata = wd; end
      1: begin bus.req1_valid = v; bus.req1_we = we; bus.req1_x = 4'(x); bus.req1_y = 5'(y); bus.req1_wdata = wd; end
      default: begin bus.req2_valid = v; bus.req2_we = we; bus.req2_x = 4'(x); bus.req2_y = 5'(y); bus.req2_wdata = wd; end
    endcase
  endtask

  function automatic int ready_vec();
    return int'({bus.req2_ready, bus.req1_ready, bus.req0_ready});
  endfunction

  // Checks one cycle against the model, advances the model, ends on next negedge
  task automatic tick();
    int g, x, y, erv, erd;
    bit v0, v1, v2, we, wd, inr;
    #1;
    v0 = bus.req0_valid; v1 = bus.req1_valid; v2 = bus.req2_valid;
    g = -1;
    if (locked) begin
      if (v0) g = 0;
    end else if (v2 && starve >= STARVE_MAX) g = 2;
    else if (v0) g = 0;
    else if (v1 && v2) begin g = rr_next; rr_next = 3 - rr_next; end
    else if (v1) begin g = 1; rr_next = 2; end
    else if (v2) begin g = 2; rr_next = 1; end
    x = 0; y = 0; we = 0; wd = 0;
    case (g)
      0: begin x = bus.req0_x; y = bus.req0_y; we = bus.req0_we; wd = bus.req0_wdata; end
      1: begin x = bus.req1_x; y = bus.req1_y; we = bus.req1_we; wd = bus.req1_wdata; end
      2: begin x = bus.req2_x; y = bus.req2_y; we = bus.req2_we; wd = bus.req2_wdata; end
      default: ;
    endcase
    inr = (x <= 9) && (y <= 19);
    chk("ready", ready_vec(), (g < 0) ? 0 : (1 << g));
    chk("mem_en", int'(bus.mem_en), int'(g >= 0 && inr));
    if (g >= 0 && inr) begin
      chk("mem_x", int'(bus.mem_x), x);
      chk("mem_y", int'(bus.mem_y), y);
      chk("mem_we", int'(bus.mem_we), int'(we));
      if (we) chk("mem_wdata", int'(bus.mem_wdata), int'(wd));
    end
    erv = 0; erd = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      erv = 1 << q[0].id; erd = q[0].val;
      void'(q.pop_front());
    end
    chk("rvalid", int'(bus.rvalid), erv);
    chk("rdata", int'(bus.rdata), erd);
    if (g >= 0) begin
      if (!we) q.push_back('{cyc + RD_LAT, g, inr ? int'(board[x][y]) : 0});
      else if (inr) board[x][y] = wd;
    end
    if (!v2 || g == 2) starve = 0;
    else if (starve < STARVE_SAT) starve++;
    if (!locked && g == 0 && bus.req0_lock) locked = 1;
    else if (locked && !bus.req0_lock) locked = 0;
    cyc++;
    @(negedge CLOCK_50);
  endtask

  task automatic idle_all();
    for (int n = 0; n < 3; n++) set_req(n, 0, 0, 0, 0, 0);
    bus.req0_lock = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with reset released
  task automatic do_reset();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) set_req(n, 1, 0, 1, 1, 0);
    #1;
    chk("rst_ready", ready_vec(), 0);
    chk("rst_mem_en", int'(bus.mem_en), 0);
    chk("rst_rvalid", int'(bus.rvalid), 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    idle_all();
    locked = 0; rr_next = 1; starve = 0; cyc = 0;
    q.delete();
  endtask

  initial begin
    int first2, r0_after;
    n_chk = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < 10; i++) for (int j = 0; j < 20; j++) board[i][j] = 0;
    idle_all();
    @(negedge CLOCK_50);

    // Fixed priority with all three requesting
    do_reset();
    set_req(0, 1, 0, 5, 7, 0); set_req(1, 1, 0, 1, 1, 0); set_req(2, 1, 0, 2, 2, 0);
    #1;
    chk("prio_ready", ready_vec(), 1);
    chk("prio_mem_x", int'(bus.mem_x), 5);
    chk("prio_mem_y", int'(bus.mem_y), 7);
    tick();

    // Line-clear / painter round-robin from reset
    do_reset();
    set_req(1, 1, 0, 4, 4, 0); set_req(2, 1, 0, 6, 6, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_order", ready_vec(), (i % 2 == 0) ? 2 : 4);
      tick();
    end

    // Painter starvation override
    do_reset();
    set_req(0, 1, 0, 1, 1, 0); set_req(2, 1, 0, 2, 2, 0);
    first2 = 0; r0_after = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (first2 == 0 && bus.req2_ready) first2 = c;
      if (c == first2 + 1 && first2 != 0) r0_after = int'(bus.req0_ready);
      tick();
    end
    chk("starve_grant_cycle", first2, 16);
    chk("starve_resume", r0_after, 1);

    // Locked write-then-read of the same cell
    do_reset();
    set_req(1, 1, 0, 3, 19, 0); set_req(2, 1, 0, 3, 19, 0);
    set_req(0, 1, 1, 3, 19, 1); bus.req0_lock = 1'b1;
    tick();
    set_req(0, 1, 0, 3, 19, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("lock_hold_ready", ready_vec(), 0);
    chk("lock_rvalid", int'(bus.rvalid), 1);
    chk("lock_rdata", int'(bus.rdata), 1);
    tick();
    bus.req0_lock = 1'b0;
    #1;
    chk("lock_release_ready", ready_vec(), 0);
    tick();
    #1;
    chk("unlocked_ready", ready_vec(), 2);
    tick();

    // Out-of-range painter read
    idle_all();
    set_req(2, 1, 0, 12, 5, 0);
    #1;
    chk("oor_mem_en", int'(bus.mem_en), 0);
    tick();
    idle_all();
    #1;
    chk("oor_rvalid", int'(bus.rvalid), 4);
    chk("oor_rdata", int'(bus.rdata), 0);
    tick();

    // Reset with a read in flight and the lock held
    set_req(0, 1, 0, 3, 19, 0); bus.req0_lock = 1'b1;
    tick();
    do_reset();
    bus.req0_lock = 1'b1;
    set_req(1, 1, 0, 0, 0, 0);
    #1;
    chk("post_rst_rvalid", int'(bus.rvalid), 0);
    chk("post_rst_unlocked", ready_vec(), 2);
    tick();
    idle_all();
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 3; n++)
        set_req(n, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                (($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9)),
                (($urandom_range(0, 7) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19)),
                $urandom_range(0, 1) == 1);
      bus.req0_lock = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
